reg_file8: RTL and testbench



---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_clear_ctrl.sv | 55 +++++
 rtl/reg_file8.sv | 71 +++++++
 tb/tb_reg_file8.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared definitions for the reg_file8 register file.
//   DEFAULT_DATA_WIDTH - default register width in bits
//   DEFAULT_ADDR_WIDTH - default address width
//   NUM_REGS           - number of entries for the default address width
//   clr_state_e        - clear sequencer states (ST_IDLE, ST_CLEAR)
package reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;
  localparam int unsigned NUM_REGS           = 2 ** DEFAULT_ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// reg_file_clear_ctrl: sequencer that zeroes the register file one entry per cycle.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   clr_req  - clear request (pulse or level); ignored while a clear is running
//   busy     - clear sequence in progress
//   clr_en   - zero the entry at clr_addr on this edge
//   clr_addr - entry being cleared
module reg_file_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          // Counter wraps to 0 by itself after the last entry.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_en   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file8.sv
// reg_file8: eight-entry register file, entry 0 hardwired to zero, two combinational
// read ports, one write port and a sequenced clear.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   ra0/ra1  - read addresses; rd0/rd1 - read data (combinational)
//   wa/wd/we - write address, data and enable (dropped while busy or wa == 0)
//   clr_req  - start a clear of all entries; busy - clear in progress
// Optional feature: define BYPASS_EN for write-through forwarding onto the read ports.
module reg_file8
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ra0,
  input  logic [ADDR_WIDTH-1:0] ra1,
  output logic [DATA_WIDTH-1:0] rd0,
  output logic [DATA_WIDTH-1:0] rd1,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  we,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int unsigned NumEntries = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumEntries];
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_fire;

  reg_file_clear_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_addr(clr_addr)
  );

  // Writes to entry 0 are discarded so it always holds zero.
  assign wr_fire = we && !busy && (wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumEntries; i++) begin
        regs_q[i] <= '0;
      end
    end else if (clr_en) begin
      regs_q[clr_addr] <= '0;
    end else if (wr_fire) begin
      regs_q[wa] <= wd;
    end
  end

  always_comb begin
    rd0 = (ra0 == '0) ? '0 : regs_q[ra0];
    rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
`ifdef BYPASS_EN
    // Forward the in-flight write so readers see it in the same cycle.
    if (wr_fire && (ra0 == wa)) rd0 = wd;
    if (wr_fire && (ra1 == wa)) rd1 = wd;
`endif
  end

endmodule

// File: tb/tb_reg_file8.sv
// tb_reg_file8: directed plus randomized self-checking bench for reg_file8, compared
// against an array-based behavioural model of the register file and clear sequence.
module tb_reg_file8;
  import reg_file_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra0, ra1, wa;
  logic [DW-1:0] rd0, rd1, wd;
  logic          we, clr_req, busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: contents, clear-in-progress flag, next entry to clear.
  logic [DW-1:0] mem [NUM_REGS];
  bit            m_busy;
  int            m_idx;

  always #5 clk = ~clk;

  reg_file8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra0    (ra0),
    .ra1    (ra1),
    .rd0    (rd0),
    .rd1    (rd1),
    .wa     (wa),
    .wd     (wd),
    .we     (we),
    .clr_req(clr_req),
    .busy   (busy)
  );

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
`ifdef BYPASS_EN
    if (we && !m_busy && wa == ra) return wd;
`endif
    return mem[ra];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " rd0"}, rd0, exp_rd(ra0));
    chk({tag, " rd1"}, rd1, exp_rd(ra1));
    chk({tag, " busy"}, DW'(busy), DW'(m_busy));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
    m_busy = 0;
    m_idx  = 0;
  endtask

  // What one rising edge does to the file, given the inputs present before it.
  task automatic model_edge();
    if (m_busy) begin
      mem[m_idx] = '0;
      m_idx++;
      if (m_idx == NUM_REGS) begin
        m_busy = 0;
        m_idx  = 0;
      end
    end else begin
      if (we && wa != 0) mem[wa] = wd;
      if (clr_req) begin
        m_busy = 1;
        m_idx  = 0;
      end
    end
  endtask

  task automatic set_in(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic c, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    we = w; wa = a; wd = d; clr_req = c; ra0 = r0; ra1 = r1;
  endtask

  // Called 1 time unit after a rising edge: check, then advance one clock.
  task automatic tick(input string tag);
    #3;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int busy_cycles;
    logic [AW-1:0] a;

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    for (int i = 0; i < NUM_REGS; i++) begin
      ra0 = AW'(i);
      ra1 = AW'(NUM_REGS - 1 - i);
      #1;
      check_outputs("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read and the hardwired-zero entry.
    set_in(1, 5, 16'h1234, 0, 5, 0);
    tick("wr5");
    set_in(0, 0, 0, 0, 5, 0);
    #3;
    chk("rd5 direct", rd0, 16'h1234);
    tick("rd5");
    set_in(1, 0, 16'hFFFF, 0, 0, 0);
    tick("wr0");
    set_in(0, 0, 0, 0, 0, 5);
    #3;
    chk("rd0 zero", rd0, 16'h0000);
    tick("rd0");

    // Fill, clear, and a write attempted mid-clear.
    for (int i = 1; i < NUM_REGS; i++) begin
      set_in(1, AW'(i), DW'(16'h0011 * i), 0, AW'(i), AW'(i - 1));
      tick("fill");
    end
    set_in(0, 0, 0, 1, 1, 7);
    tick("clr start");
    busy_cycles = 0;
    for (int i = 0; i < NUM_REGS + 1; i++) begin
      if (busy) busy_cycles++;
      set_in(i == 2, 3, 16'h5A5A, 0, 3, AW'(i));
      tick("clr run");
    end
    chk("busy length", DW'(busy_cycles), DW'(8));
    for (int i = 0; i < NUM_REGS; i++) begin
      set_in(0, 0, 0, 0, AW'(i), AW'(i));
      tick("after clr");
      chk("after clr zero", rd0, 16'h0000);
    end

    // Write and clear request on the same edge.
    set_in(1, 2, 16'hAAAA, 1, 2, 2);
    tick("wr+clr");
    set_in(0, 0, 0, 0, 2, 2);
    #3;
    chk("wr+clr R2", rd0, 16'hAAAA);
    for (int i = 0; i < NUM_REGS + 1; i++) tick("wr+clr run");
    chk("wr+clr R2 cleared", rd0, 16'h0000);

    // Reset during the fourth cycle of a clear.
    for (int i = 1; i < NUM_REGS; i++) begin
      set_in(1, AW'(i), DW'($urandom), 0, 0, 0);
      tick("refill");
    end
    set_in(0, 0, 0, 1, 6, 7);
    tick("clr2 start");
    set_in(0, 0, 0, 0, 6, 7);
    for (int i = 0; i < 3; i++) tick("clr2 run");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_in(0, 0, 0, 0, AW'(i), AW'(NUM_REGS - 1 - i));
      tick("post abort");
    end

    // Forwarding behaviour on a read of the entry being written.
    set_in(1, 4, 16'h1111, 0, 0, 0);
    tick("pre bypass");
    set_in(1, 4, 16'hBEEF, 0, 0, 4);
    #3;
`ifdef BYPASS_EN
    chk("bypass same cycle", rd1, 16'hBEEF);
`else
    chk("no bypass same cycle", rd1, 16'h1111);
`endif
    #1;
    @(posedge clk);
    model_edge();
    #1;
    set_in(0, 0, 0, 0, 0, 4);
    #3;
    chk("bypass next cycle", rd1, 16'hBEEF);
    tick("post bypass");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      a = AW'($urandom_range(0, NUM_REGS - 1));
      set_in(1'($urandom_range(0, 1)), a, DW'($urandom),
             $urandom_range(0, 15) == 0,
             ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, NUM_REGS - 1)),
             AW'($urandom_range(0, NUM_REGS - 1)));
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
